// File: rtl/instrument_uart_tx.sv
// instrument_uart_tx: packs bass, drum and guitar note state into the 3-byte
// instrument protocol and sends each changed byte as 8N1 UART on TxD.
// Byte layout: [2:0] instrument ID (001 bass, 010 drum, 100 guitar);
// bass/guitar carry a 5-bit note in [7:3]; drum carries a 4-bit note in [6:3]
// and the foot pedal in [7].
// Optional build macro INSTRUMENT_TX_REFRESH_EN adds a periodic keepalive that
// resends all three instruments every REFRESH_CYCLES clocks.
module instrument_uart_tx #(
    parameter int unsigned CLKS_PER_BIT   = 434,
    parameter int unsigned REFRESH_CYCLES = 5000000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       send_en,
    input  logic [4:0] bass,
    input  logic [3:0] drum,
    input  logic       drum_foot,
    input  logic [4:0] guitar,
    output logic       TxD,
    output logic       busy,
    output logic       frame_done,
    output logic [2:0] last_id
);

    localparam logic [1:0] StIdle  = 2'd0;
    localparam logic [1:0] StStart = 2'd1;
    localparam logic [1:0] StData  = 2'd2;
    localparam logic [1:0] StStop  = 2'd3;

    localparam logic [15:0] BaudLast = 16'(CLKS_PER_BIT - 1);

    // Instrument index used by the arbiter: 0 bass, 1 drum, 2 guitar.
    localparam logic [1:0] IdxBass   = 2'd0;
    localparam logic [1:0] IdxDrum   = 2'd1;
    localparam logic [1:0] IdxGuitar = 2'd2;

    logic [1:0]  state_q, state_d;
    logic [15:0] baud_q, baud_d;
    logic [2:0]  bit_q, bit_d;
    logic [7:0]  shift_q, shift_d;
    logic        txd_q, txd_d;
    logic        done_q, done_d;
    logic [2:0]  last_id_q, last_id_d;
    logic [1:0]  rr_q, rr_d;
    logic [4:0]  sent_bass_q, sent_bass_d;
    logic [4:0]  sent_drum_q, sent_drum_d;
    logic [4:0]  sent_gtr_q, sent_gtr_d;
    logic [2:0]  pend_q, pend_d;

    logic [4:0]  drum_state;
    logic [7:0]  byte_bass, byte_drum, byte_gtr, load_byte;
    logic [2:0]  diff;
    logic [2:0]  refresh_need;
    logic [2:0]  eligible;
    logic        sel_valid;
    logic [1:0]  sel;
    logic [1:0]  cand;
    logic        load;
    logic        baud_last;

    assign drum_state = {drum_foot, drum};
    assign byte_bass  = {bass, 3'b001};
    assign byte_drum  = {drum_foot, drum, 3'b010};
    assign byte_gtr   = {guitar, 3'b100};

    // Live difference against what was last sent for each instrument.
    assign diff = {guitar != sent_gtr_q, drum_state != sent_drum_q, bass != sent_bass_q};

    // The registered pend is qualified by the live compare so a value that
    // returns to its last-sent state in the cycle before a load is not resent.
    assign eligible = (pend_q & diff) | refresh_need;

    // Round-robin pick: first eligible instrument at or after rr_q.
    always_comb begin
        sel_valid = 1'b0;
        sel       = IdxBass;
        cand      = rr_q;
        for (int k = 0; k < 3; k++) begin
            if (!sel_valid && eligible[cand]) begin
                sel_valid = 1'b1;
                sel       = cand;
            end
            cand = (cand == IdxGuitar) ? IdxBass : cand + 2'd1;
        end
    end

    assign load = (state_q == StIdle) && send_en && sel_valid;

    // Byte that would be loaded for the selected instrument.
    always_comb begin
        unique case (sel)
            IdxDrum:   load_byte = byte_drum;
            IdxGuitar: load_byte = byte_gtr;
            default:   load_byte = byte_bass;
        endcase
    end

    assign baud_last = (baud_q == BaudLast);

    // Next-state logic for the frame sequencer, load path and change tracking.
    always_comb begin
        state_d     = state_q;
        baud_d      = baud_q;
        bit_d       = bit_q;
        shift_d     = shift_q;
        txd_d       = txd_q;
        done_d      = 1'b0;
        last_id_d   = last_id_q;
        rr_d        = rr_q;
        sent_bass_d = sent_bass_q;
        sent_drum_d = sent_drum_q;
        sent_gtr_d  = sent_gtr_q;

        case (state_q)
            StIdle: begin
                txd_d  = 1'b1;
                baud_d = '0;
                bit_d  = '0;
                if (load) begin
                    shift_d   = load_byte;
                    last_id_d = load_byte[2:0];
                    rr_d      = (sel == IdxGuitar) ? IdxBass : sel + 2'd1;
                    unique case (sel)
                        IdxDrum:   sent_drum_d = drum_state;
                        IdxGuitar: sent_gtr_d  = guitar;
                        default:   sent_bass_d = bass;
                    endcase
                    state_d = StStart;
                    txd_d   = 1'b0;
                end
            end
            StStart: begin
                if (baud_last) begin
                    baud_d  = '0;
                    state_d = StData;
                    txd_d   = shift_q[0];
                end else begin
                    baud_d = baud_q + 16'd1;
                end
            end
            StData: begin
                if (baud_last) begin
                    baud_d = '0;
                    bit_d  = bit_q + 3'd1;
                    if (bit_q == 3'd7) begin
                        state_d = StStop;
                        txd_d   = 1'b1;
                    end else begin
                        shift_d = {1'b0, shift_q[7:1]};
                        txd_d   = shift_q[1];
                    end
                end else begin
                    baud_d = baud_q + 16'd1;
                end
            end
            default: begin
                if (baud_last) begin
                    baud_d  = '0;
                    state_d = StIdle;
                    done_d  = 1'b1;
                end else begin
                    baud_d = baud_q + 16'd1;
                end
            end
        endcase

        // Compare against the post-load sent value so a just-loaded
        // instrument does not look pending for one extra cycle.
        pend_d = {guitar != sent_gtr_d, drum_state != sent_drum_d, bass != sent_bass_d};
    end

    // Sequencer, shift register and change-tracking state.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            baud_q      <= '0;
            bit_q       <= '0;
            shift_q     <= '0;
            txd_q       <= 1'b1;
            done_q      <= 1'b0;
            last_id_q   <= '0;
            rr_q        <= IdxBass;
            sent_bass_q <= '0;
            sent_drum_q <= '0;
            sent_gtr_q  <= '0;
            pend_q      <= '0;
        end else begin
            state_q     <= state_d;
            baud_q      <= baud_d;
            bit_q       <= bit_d;
            shift_q     <= shift_d;
            txd_q       <= txd_d;
            done_q      <= done_d;
            last_id_q   <= last_id_d;
            rr_q        <= rr_d;
            sent_bass_q <= sent_bass_d;
            sent_drum_q <= sent_drum_d;
            sent_gtr_q  <= sent_gtr_d;
            pend_q      <= pend_d;
        end
    end

`ifdef INSTRUMENT_TX_REFRESH_EN
    localparam int unsigned RefW = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;
    localparam logic [RefW-1:0] RefLast = RefW'(REFRESH_CYCLES - 1);

    logic [RefW-1:0] ref_cnt_q, ref_cnt_d;
    logic [2:0]      ref_need_q, ref_need_d;

    // Keepalive: count while no refresh is outstanding, then force all three
    // instruments pending; each load retires its own bit.
    always_comb begin
        ref_cnt_d  = ref_cnt_q;
        ref_need_d = ref_need_q;
        if (load) begin
            ref_need_d[sel] = 1'b0;
        end
        if (ref_need_q == 3'b000) begin
            if (ref_cnt_q == RefLast) begin
                ref_cnt_d  = '0;
                ref_need_d = 3'b111;
            end else begin
                ref_cnt_d = ref_cnt_q + 1'b1;
            end
        end
    end

    // Keepalive counter and outstanding-refresh bits.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ref_cnt_q  <= '0;
            ref_need_q <= '0;
        end else begin
            ref_cnt_q  <= ref_cnt_d;
            ref_need_q <= ref_need_d;
        end
    end

    assign refresh_need = ref_need_q;
`else
    assign refresh_need = 3'b000;
`endif

    assign TxD        = txd_q;
    assign busy       = (state_q != StIdle);
    assign frame_done = done_q;
    assign last_id    = last_id_q;

endmodule

// File: tb/tb_instrument_uart_tx.sv
// Bench for instrument_uart_tx with CLKS_PER_BIT=4, REFRESH_CYCLES=200.
// A negedge receiver decodes TxD into frames and records the inputs seen at
// the load edge; expected bytes come from the protocol packing rules.
module tb_instrument_uart_tx;

    localparam int CPB = 4;
    localparam int REF = 200;
    localparam int FRAME = 10 * CPB;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       send_en;
    logic [4:0] bass;
    logic [3:0] drum;
    logic       drum_foot;
    logic [4:0] guitar;
    logic       TxD;
    logic       busy;
    logic       frame_done;
    logic [2:0] last_id;

    instrument_uart_tx #(
        .CLKS_PER_BIT  (CPB),
        .REFRESH_CYCLES(REF)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .send_en   (send_en),
        .bass      (bass),
        .drum      (drum),
        .drum_foot (drum_foot),
        .guitar    (guitar),
        .TxD       (TxD),
        .busy      (busy),
        .frame_done(frame_done),
        .last_id   (last_id)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [4:0] bass;
        logic [3:0] drum;
        logic       foot;
        logic [4:0] guitar;
        logic       en;
    } snap_t;

    typedef struct {
        logic [9:0] wire_bits;
        logic       hold_ok;
        logic       tail_ok;
        int         start;
        snap_t      snap;
    } frame_t;

    frame_t frames[$];
    frame_t cur;
    snap_t  prev_snap;
    bit     in_frame = 1'b0;
    int     mcnt = 0;
    int     done_cnt = 0;
    int     busy_cnt = 0;
    int     n_checks = 0;
    int     n_err = 0;

    // Receiver: detects the start bit, checks each bit is held CPB cycles,
    // and expects frame_done with the line idle exactly FRAME cycles later.
    always @(negedge clk) begin
        if (rst_n !== 1'b1) begin
            in_frame = 1'b0;
        end else begin
            if (frame_done === 1'b1) done_cnt++;
            if (busy === 1'b1) busy_cnt++;
            if (!in_frame) begin
                if (TxD === 1'b0) begin
                    in_frame          = 1'b1;
                    mcnt              = 0;
                    cur.wire_bits     = '0;
                    cur.wire_bits[0]  = TxD;
                    cur.hold_ok       = (busy === 1'b1);
                    cur.tail_ok       = 1'b1;
                    cur.start         = cyc;
                    cur.snap          = prev_snap;
                end
            end else begin
                mcnt++;
                if (mcnt < FRAME) begin
                    if (mcnt % CPB == 0) cur.wire_bits[4'(mcnt / CPB)] = TxD;
                    else if (TxD !== cur.wire_bits[4'(mcnt / CPB)]) cur.hold_ok = 1'b0;
                    if (busy !== 1'b1) cur.hold_ok = 1'b0;
                    if (frame_done !== 1'b0) cur.tail_ok = 1'b0;
                end else begin
                    if (!(frame_done === 1'b1 && busy === 1'b0 && TxD === 1'b1))
                        cur.tail_ok = 1'b0;
                    frames.push_back(cur);
                    in_frame = 1'b0;
                end
            end
        end
        prev_snap = '{bass, drum, drum_foot, guitar, send_en};
    end

    function automatic logic [7:0] pack_exp(input snap_t s, input logic [7:0] got);
        case (got[2:0])
            3'b001:  return {s.bass, 3'b001};
            3'b010:  return {s.foot, s.drum, 3'b010};
            3'b100:  return {s.guitar, 3'b100};
            default: return ~got;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_frames(input int n, input int budget, input string tag);
        int t = 0;
        while (frames.size() < n && t < budget) begin
            tick(1);
            t++;
        end
        chk({tag, "_count"}, frames.size(), n);
    endtask

    task automatic wait_start(input int budget, input string tag);
        int t = 0;
        while (!in_frame && t < budget) begin
            tick(1);
            t++;
        end
        chk({tag, "_started"}, 32'(in_frame), 1);
    endtask

    task automatic chk_frame(input int i, input logic [7:0] exp, input string tag);
        if (frames.size() > i) begin
            chk({tag, "_byte"}, frames[i].wire_bits[8:1], exp);
            chk({tag, "_timing"}, {frames[i].hold_ok, frames[i].tail_ok}, 2'b11);
        end else begin
            chk({tag, "_present"}, frames.size(), i + 1);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick(3);
        rst_n = 1'b1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [4:0] m_sent [3];
        logic [4:0] val;
        logic [2:0] id;
        rst_n     = 1'b0;
        send_en   = 1'b1;
        bass      = '0;
        drum      = '0;
        drum_foot = 1'b0;
        guitar    = '0;
        tick(3);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_txd", TxD, 1);
        chk("rst_busy", busy, 0);
        chk("rst_done", frame_done, 0);
        chk("rst_last_id", last_id, 0);
        tick(1);

`ifdef INSTRUMENT_TX_REFRESH_EN
        // Static nonzero bass: after the change frame, keepalive rounds repeat.
        bass = 5'd2;
        tick(1200);
        chk("refresh_enough_frames", 32'(frames.size() >= 7), 1);
        for (int i = 0; i < frames.size(); i++) begin
            logic [7:0] seq [3];
            seq[0] = 8'h11;
            seq[1] = 8'h02;
            seq[2] = 8'h04;
            chk($sformatf("refresh_seq%0d", i), frames[i].wire_bits[8:1], seq[i % 3]);
        end
`else
        // Idle with all-zero inputs: nothing on the wire.
        tick(1000);
        chk("idle_frames", frames.size(), 0);
        chk("idle_done", done_cnt, 0);
        chk("idle_busy", busy_cnt, 0);
        chk("idle_txd", TxD, 1);

        // Single bass change.
        bass = 5'b00011;
        wait_frames(1, 200, "bass");
        chk_frame(0, 8'h19, "bass");
        if (frames.size() > 0) begin
            chk("bass_wire", frames[0].wire_bits, 10'b1_0001_1001_0);
            chk("bass_model", frames[0].wire_bits[8:1],
                pack_exp(frames[0].snap, frames[0].wire_bits[8:1]));
        end
        chk("bass_last_id", last_id, 3'b001);
        frames.delete();

        // Drum with foot.
        drum      = 4'b1010;
        drum_foot = 1'b1;
        wait_frames(1, 200, "drum");
        chk_frame(0, 8'hD2, "drum");
        chk("drum_last_id", last_id, 3'b010);

        // Simultaneous change on all three after reset: round-robin from bass.
        bass = '0; drum = '0; drum_foot = 1'b0; guitar = '0;
        do_reset();
        frames.delete();
        bass = 5'd1; drum = 4'd1; guitar = 5'd1;
        wait_frames(3, 400, "rr");
        chk_frame(0, 8'h09, "rr0");
        chk_frame(1, 8'h0A, "rr1");
        chk_frame(2, 8'h0C, "rr2");
        if (frames.size() == 3) begin
            chk("rr_gap01", frames[1].start - frames[0].start, FRAME + 1);
            chk("rr_gap12", frames[2].start - frames[1].start, FRAME + 1);
        end
        chk("rr_last_id", last_id, 3'b100);
        frames.delete();

        // Change during a frame: the newer value follows in a second frame.
        guitar = 5'd3;
        wait_start(100, "mid");
        tick(10);
        guitar = 5'd7;
        wait_frames(2, 400, "mid");
        chk_frame(0, 8'h1C, "mid0");
        chk_frame(1, 8'h3C, "mid1");
        frames.delete();

        // send_en low holds the change until it returns.
        send_en = 1'b0;
        tick(1);
        bass = 5'd9;
        tick(200);
        chk("hold_frames", frames.size(), 0);
        chk("hold_txd", TxD, 1);
        send_en = 1'b1;
        wait_frames(1, 200, "release");
        chk_frame(0, 8'h49, "release");
        frames.delete();

        // Reset in the middle of data bits, then full resend.
        drum      = 4'd5;
        drum_foot = 1'b1;
        wait_start(100, "abort");
        tick(12);
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("abort_txd", TxD, 1);
        chk("abort_busy", busy, 0);
        chk("abort_last_id", last_id, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        frames.delete();
        wait_frames(3, 400, "resend");
        chk_frame(0, 8'h49, "resend0");
        chk_frame(1, 8'hAA, "resend1");
        chk_frame(2, 8'h3C, "resend2");
        tick(5);
        frames.delete();

        // Random changes and send_en toggling; every frame must carry the
        // value present at its load edge, never repeat the last value sent
        // for that instrument, and the final values must all get through.
        m_sent[0] = bass;
        m_sent[1] = {drum_foot, drum};
        m_sent[2] = guitar;
        for (int it = 0; it < 40; it++) begin
            tick($urandom_range(1, 60));
            case ($urandom_range(0, 3))
                0: bass = 5'($urandom);
                1: begin drum = 4'($urandom); drum_foot = 1'($urandom); end
                2: guitar = 5'($urandom);
                default: send_en = ~send_en;
            endcase
        end
        send_en = 1'b1;
        tick(500);
        for (int i = 0; i < frames.size(); i++) begin
            id = frames[i].wire_bits[3:1];
            chk($sformatf("rnd%0d_byte", i), frames[i].wire_bits[8:1],
                pack_exp(frames[i].snap, frames[i].wire_bits[8:1]));
            chk($sformatf("rnd%0d_en", i), frames[i].snap.en, 1);
            chk($sformatf("rnd%0d_timing", i), {frames[i].hold_ok, frames[i].tail_ok}, 2'b11);
            val = frames[i].wire_bits[8:4];
            if (id == 3'b010) val = {frames[i].wire_bits[8], frames[i].wire_bits[7:4]};
            if (id == 3'b001) begin
                chk($sformatf("rnd%0d_fresh", i), 32'(val != m_sent[0]), 1);
                m_sent[0] = val;
            end else if (id == 3'b010) begin
                chk($sformatf("rnd%0d_fresh", i), 32'(val != m_sent[1]), 1);
                m_sent[1] = val;
            end else if (id == 3'b100) begin
                chk($sformatf("rnd%0d_fresh", i), 32'(val != m_sent[2]), 1);
                m_sent[2] = val;
            end
        end
        chk("rnd_final_bass", m_sent[0], bass);
        chk("rnd_final_drum", m_sent[1], {drum_foot, drum});
        chk("rnd_final_guitar", m_sent[2], guitar);
        chk("rnd_idle_busy", busy, 0);
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
